// File: rtl/if_fetch_unit_if.sv
// if_fetch_unit_if: instruction-memory read port between the fetch stage and imem.
//
// Signals:
//   imem_req   - read request from the fetch stage
//   imem_addr  - read address, held stable while a request waits for ready
//   imem_ready - read data valid this cycle (may coincide with the request)
//   imem_rdata - instruction word returned by memory
//
// Modports:
//   master - fetch-stage side (drives req/addr)
//   slave  - memory side (drives ready/rdata)
interface if_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage and producer side of the IF/ID register.
//
// Owns the PC, issues instruction-memory reads over a ready handshake, applies
// hazard stalls and ID-stage redirects. The IF/ID register has no hold input, so
// a stalled instruction is captured here and re-presented every stall cycle.
//
// Parameters:
//   RESET_PC    - PC loaded on reset
// Ports:
//   CLK, RESET  - clock, synchronous active-high reset
//   StallF      - hold the PC (hazard unit)
//   PCSrcD      - redirect taken in ID
//   PCBranchD   - redirect target
//   imem        - instruction-memory read port (master)
//   InstrF      - to IF/ID instruction_in
//   PCPlus4F    - PCF + 4 (wraps modulo 2^32)
//   PCF         - current fetch PC
//   FetchValidF - InstrF holds a real instruction
//   FlushD      - to IF/ID ENABLE; 1 loads a bubble
//   StallCntF   - fetch-bubble counter
//   RedirCntF   - redirect counter
//
// Build option:
//   FETCH_PERF_EN - when defined, builds saturating StallCntF/RedirCntF counters;
//                   otherwise both outputs are tied to zero.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   StallF,
    input  logic                   PCSrcD,
    input  logic [31:0]            PCBranchD,
    if_fetch_unit_if.master        imem,
    output logic [31:0]            InstrF,
    output logic [31:0]            PCPlus4F,
    output logic [31:0]            PCF,
    output logic                   FetchValidF,
    output logic                   FlushD,
    output logic [31:0]            StallCntF,
    output logic [31:0]            RedirCntF
);

    // StHold: instruction captured during a stall, memory idle.
    // StDrain: redirect arrived while a read was outstanding; wait it out, drop the data.
    typedef enum logic [1:0] {StFetch, StHold, StDrain} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] tgt_q, tgt_d;
    logic [31:0] pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;

    // Outputs
    always_comb begin
        PCF            = pc_q;
        PCPlus4F       = pc_plus4;
        imem.imem_addr = pc_q;
        InstrF         = (state_q == StHold) ? instr_q : imem.imem_rdata;
        if (RESET) begin
            imem.imem_req = 1'b0;
            FetchValidF   = 1'b0;
        end else begin
            imem.imem_req = (state_q != StHold);
            FetchValidF   = ((state_q == StFetch) && imem.imem_ready) || (state_q == StHold);
        end
        FlushD = !FetchValidF || PCSrcD;
    end

    // Next state; reset is applied in the register block
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        tgt_d   = tgt_q;
        unique case (state_q)
            StFetch: begin
                if (PCSrcD) begin
                    if (imem.imem_ready) begin
                        pc_d = PCBranchD;
                    end else begin
                        // The outstanding request cannot be withdrawn.
                        tgt_d   = PCBranchD;
                        state_d = StDrain;
                    end
                end else if (imem.imem_ready) begin
                    if (StallF) begin
                        instr_d = imem.imem_rdata;
                        state_d = StHold;
                    end else begin
                        pc_d = pc_plus4;
                    end
                end
            end
            StHold: begin
                if (PCSrcD) begin
                    pc_d    = PCBranchD;
                    state_d = StFetch;
                end else if (!StallF) begin
                    pc_d    = pc_plus4;
                    state_d = StFetch;
                end
            end
            StDrain: begin
                if (PCSrcD) begin
                    tgt_d = PCBranchD;
                end
                if (imem.imem_ready) begin
                    // Latest redirect wins, including one arriving this cycle.
                    pc_d    = PCSrcD ? PCBranchD : tgt_q;
                    state_d = StFetch;
                end
            end
            default: begin
                state_d = StFetch;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= StFetch;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            tgt_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            tgt_q   <= tgt_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] redir_cnt_q, redir_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        redir_cnt_d = redir_cnt_q;
        if (!FetchValidF && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (PCSrcD && (redir_cnt_q != 32'hFFFF_FFFF)) begin
            redir_cnt_d = redir_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            stall_cnt_q <= 32'h0;
            redir_cnt_q <= 32'h0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            redir_cnt_q <= redir_cnt_d;
        end
    end

    assign StallCntF = stall_cnt_q;
    assign RedirCntF = redir_cnt_q;
`else
    assign StallCntF = 32'h0;
    assign RedirCntF = 32'h0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed scenarios plus randomized traffic against a
// behavioural model of the fetch stage.
module tb_if_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0040;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        src = 1'b0;
    logic [31:0] tgt = 32'h0;
    logic        rdy = 1'b0;
    logic [31:0] rdata = 32'h0;

    logic [31:0] InstrF, PCPlus4F, PCF, StallCntF, RedirCntF;
    logic        FetchValidF, FlushD;

    int n_vec = 0;
    int n_err = 0;

    if_fetch_unit_if bus ();
    assign bus.imem_ready = rdy;
    assign bus.imem_rdata = rdata;

    if_fetch_unit #(
        .RESET_PC (RST_PC)
    ) dut (
        .CLK         (clk),
        .RESET       (rst),
        .StallF      (stall),
        .PCSrcD      (src),
        .PCBranchD   (tgt),
        .imem        (bus.master),
        .InstrF      (InstrF),
        .PCPlus4F    (PCPlus4F),
        .PCF         (PCF),
        .FetchValidF (FetchValidF),
        .FlushD      (FlushD),
        .StallCntF   (StallCntF),
        .RedirCntF   (RedirCntF)
    );

    always #5 clk = ~clk;

    // Reference model: a PC, an optional held instruction and an optional
    // pending redirect that waits for the in-flight read to complete.
    logic [31:0] m_pc, m_held, m_dt, m_sc, m_rc;
    logic        m_hv, m_dv;
    logic [31:0] n_pc, n_held, n_dt, n_sc, n_rc;
    logic        n_hv, n_dv;
    logic        e_valid, e_req, e_flush;
    logic [31:0] e_instr, e_sc, e_rc;

    always_comb begin
        e_valid = !rst && (m_hv || (!m_dv && rdy));
        e_req   = !rst && !m_hv;
        e_flush = !e_valid || src;
        e_instr = m_hv ? m_held : rdata;
`ifdef FETCH_PERF_EN
        e_sc = m_sc;
        e_rc = m_rc;
`else
        e_sc = 32'h0;
        e_rc = 32'h0;
`endif
    end

    always_comb begin
        n_pc = m_pc; n_held = m_held; n_dt = m_dt; n_sc = m_sc; n_rc = m_rc;
        n_hv = m_hv; n_dv = m_dv;
        if (rst) begin
            n_pc = RST_PC; n_held = 32'h0; n_dt = 32'h0; n_sc = 32'h0; n_rc = 32'h0;
            n_hv = 1'b0; n_dv = 1'b0;
        end else begin
            if (!e_valid && m_sc != 32'hFFFF_FFFF) n_sc = m_sc + 1;
            if (src && m_rc != 32'hFFFF_FFFF) n_rc = m_rc + 1;
            if (m_hv) begin
                if (src) begin
                    n_pc = tgt; n_hv = 1'b0;
                end else if (!stall) begin
                    n_pc = m_pc + 4; n_hv = 1'b0;
                end
            end else if (m_dv) begin
                if (rdy) begin
                    n_pc = src ? tgt : m_dt; n_dv = 1'b0;
                end else if (src) begin
                    n_dt = tgt;
                end
            end else if (src) begin
                if (rdy) n_pc = tgt;
                else begin
                    n_dv = 1'b1; n_dt = tgt;
                end
            end else if (rdy) begin
                if (stall) begin
                    n_hv = 1'b1; n_held = rdata;
                end else begin
                    n_pc = m_pc + 4;
                end
            end
        end
    end

    always @(posedge clk) begin
        m_pc <= n_pc; m_held <= n_held; m_dt <= n_dt; m_sc <= n_sc; m_rc <= n_rc;
        m_hv <= n_hv; m_dv <= n_dv;
    end

    // Apply one cycle of inputs just after the edge; return at the negedge to sample.
    task automatic drive(input logic r, input logic s, input logic p, input logic [31:0] t,
                         input logic y, input logic [31:0] d);
        @(posedge clk);
        #1;
        rst = r; stall = s; src = p; tgt = t; rdy = y; rdata = d;
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1234_5678);
        n_vec++;
        if (bus.imem_req !== 1'b0) begin
            n_err++; $display("FAIL reset_req: got %b want 0", bus.imem_req);
        end
        n_vec++;
        if (FlushD !== 1'b1) begin
            n_err++; $display("FAIL reset_flush: got %b want 1", FlushD);
        end
        n_vec++;
        if (PCF !== 32'h40) begin
            n_err++; $display("FAIL reset_pc: got %h want 00000040", PCF);
        end
        n_vec++;
        if (StallCntF !== 32'h0 || RedirCntF !== 32'h0) begin
            n_err++; $display("FAIL reset_cnt: got %h/%h want 0/0", StallCntF, RedirCntF);
        end
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hA000_0000 + i);
            n_vec++;
            if (PCF !== RST_PC + 4 * i || PCPlus4F !== RST_PC + 4 * i + 4) begin
                n_err++;
                $display("FAIL seq_pc[%0d]: got %h/%h want %h/%h", i, PCF, PCPlus4F,
                         RST_PC + 4 * i, RST_PC + 4 * i + 4);
            end
            n_vec++;
            if (FlushD !== 1'b0 || InstrF !== 32'hA000_0000 + i) begin
                n_err++;
                $display("FAIL seq_instr[%0d]: got flush=%b instr=%h want 0/%h", i, FlushD,
                         InstrF, 32'hA000_0000 + i);
            end
        end
    endtask

    task automatic test_stall();
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h8C01_0004);
        n_vec++;
        if (InstrF !== 32'h8C01_0004 || PCF !== 32'h4C || FlushD !== 1'b0) begin
            n_err++;
            $display("FAIL stall_fetch: got %h/%h/%b want 8c010004/0000004c/0", InstrF, PCF,
                     FlushD);
        end
        for (int k = 0; k < 3; k++) begin
            // Last iteration releases the stall; the held word is consumed that cycle.
            drive(1'b0, (k < 2), 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
            n_vec++;
            if (InstrF !== 32'h8C01_0004 || PCF !== 32'h4C || FlushD !== 1'b0 ||
                PCPlus4F !== 32'h50 || bus.imem_req !== 1'b0) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: got instr=%h pc=%h flush=%b p4=%h req=%b",
                         k, InstrF, PCF, FlushD, PCPlus4F, bus.imem_req);
            end
        end
    endtask

    task automatic test_redirect_zero_wait();
        drive(1'b0, 1'b0, 1'b1, 32'h100, 1'b1, 32'h1111_1111);
        n_vec++;
        if (PCF !== 32'h50 || FlushD !== 1'b1) begin
            n_err++; $display("FAIL redir_flush: got pc=%h flush=%b want 00000050/1", PCF, FlushD);
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h2222_2222);
        n_vec++;
        if (bus.imem_addr !== 32'h100 || FlushD !== 1'b0) begin
            n_err++;
            $display("FAIL redir_addr: got %h/%b want 00000100/0", bus.imem_addr, FlushD);
        end
    endtask

    task automatic test_redirect_drain();
        // PC is now 0x104; redirect on the first wait cycle of a slow read.
        drive(1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        n_vec++;
        if (bus.imem_addr !== 32'h104 || bus.imem_req !== 1'b1 || FetchValidF !== 1'b0) begin
            n_err++;
            $display("FAIL drain_wait: got addr=%h req=%b valid=%b want 00000104/1/0",
                     bus.imem_addr, bus.imem_req, FetchValidF);
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h3333_3333);
        n_vec++;
        if (bus.imem_addr !== 32'h104 || FetchValidF !== 1'b0 || FlushD !== 1'b1) begin
            n_err++;
            $display("FAIL drain_drop: got addr=%h valid=%b flush=%b want 00000104/0/1",
                     bus.imem_addr, FetchValidF, FlushD);
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h4444_4444);
        n_vec++;
        if (bus.imem_addr !== 32'h100 || FetchValidF !== 1'b1) begin
            n_err++;
            $display("FAIL drain_target: got %h/%b want 00000100/1", bus.imem_addr, FetchValidF);
        end
    endtask

    task automatic test_wrap();
        drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
        n_vec++;
        if (PCF !== 32'hFFFF_FFFC || PCPlus4F !== 32'h0) begin
            n_err++; $display("FAIL wrap_p4: got %h/%h want fffffffc/00000000", PCF, PCPlus4F);
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
        n_vec++;
        if (PCF !== 32'h0) begin
            n_err++; $display("FAIL wrap_pc: got %h want 00000000", PCF);
        end
    endtask

    task automatic test_reset_mid_drain();
        drive(1'b0, 1'b0, 1'b1, 32'h300, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h5555_5555);
        n_vec++;
        if (bus.imem_req !== 1'b0 || FlushD !== 1'b1) begin
            n_err++; $display("FAIL rst_drain_req: got %b/%b want 0/1", bus.imem_req, FlushD);
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h6666_6666);
        n_vec++;
        if (PCF !== 32'h40 || FetchValidF !== 1'b1) begin
            n_err++; $display("FAIL rst_drain_pc: got %h/%b want 00000040/1", PCF, FetchValidF);
        end
    endtask

    task automatic test_perf_counters();
        logic [5:0] rdy_pat;
        logic [31:0] exp_sc, exp_rc;
        rdy_pat = 6'b100100;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        for (int c = 0; c < 6; c++) begin
            drive(1'b0, 1'b0, (c == 5), 32'h200, rdy_pat[c], 32'h7000_0000 + c);
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
`ifdef FETCH_PERF_EN
        exp_sc = 32'd4;
        exp_rc = 32'd1;
`else
        exp_sc = 32'd0;
        exp_rc = 32'd0;
`endif
        n_vec++;
        if (StallCntF !== exp_sc || RedirCntF !== exp_rc) begin
            n_err++;
            $display("FAIL perf_cnt: got %0d/%0d want %0d/%0d", StallCntF, RedirCntF, exp_sc,
                     exp_rc);
        end
        n_vec++;
        if (PCF !== 32'h200) begin
            n_err++; $display("FAIL perf_pc: got %h want 00000200", PCF);
        end
    endtask

    task automatic test_random();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        for (int c = 0; c < 1500; c++) begin
            drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 5) == 0), $urandom & 32'hFFFF_FFFC,
                  ($urandom_range(0, 9) < 6), $urandom);
            n_vec++;
            if ({bus.imem_req, bus.imem_addr, PCF, PCPlus4F, InstrF, FetchValidF, FlushD,
                 StallCntF, RedirCntF} !==
                {e_req, m_pc, m_pc, m_pc + 32'd4, e_instr, e_valid, e_flush, e_sc, e_rc}) begin
                n_err++;
                $display("FAIL rand[%0d]: got req=%b pc=%h p4=%h instr=%h v=%b fl=%b sc=%0d rc=%0d want req=%b pc=%h p4=%h instr=%h v=%b fl=%b sc=%0d rc=%0d",
                         c, bus.imem_req, PCF, PCPlus4F, InstrF, FetchValidF, FlushD,
                         StallCntF, RedirCntF, e_req, m_pc, m_pc + 32'd4, e_instr, e_valid,
                         e_flush, e_sc, e_rc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_zero_wait();
        test_redirect_drain();
        test_wrap();
        test_reset_mid_drain();
        test_perf_counters();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
